// File: rtl/dds_sweep_ctrl.sv
// dds_sweep_ctrl: frequency sweep scheduler driving a DDS core's freq/phase/en.
// Steps a signed tuning word from f_start to f_stop in f_step increments and
// holds each word for max(dwell,1) cycles. Steps are clamped to the target
// word, so the sweep never overshoots or wraps.
// Build option: define DDS_SWEEP_BIDIR_EN to reverse at f_stop and sweep back
// to f_start before finishing. The turnaround word is dwelt once.
//
// state | meaning
// IDLE  | waiting for start; freq/phase hold their last values, dds_en low
// RUN   | sweep in progress; busy and dds_en high
// FIN   | one-cycle done pulse, then back to IDLE
module dds_sweep_ctrl #(
  parameter int PW = 32,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic [PW-1:0] f_start,
  input  logic [PW-1:0] f_stop,
  input  logic [PW-1:0] f_step,
  input  logic [CW-1:0] dwell,
  input  logic [PW-1:0] phase_in,
  output logic [PW-1:0] freq,
  output logic [PW-1:0] phase,
  output logic          dds_en,
  output logic          busy,
  output logic          done
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_t;

  // f_step is a full-width unsigned magnitude, so a signed freq plus the step
  // needs two extra bits to be represented without wrap.
  localparam int XW = PW + 2;

  state_t        state;
  logic [PW-1:0] tgt;
  logic [PW-1:0] step_r;
  logic [CW-1:0] reload;
  logic [CW-1:0] cnt;
  logic          dir_up;
`ifdef DDS_SWEEP_BIDIR_EN
  logic [PW-1:0] origin;
  logic          back;
`endif

  logic          at_tgt;
  logic          turn;
  logic [PW-1:0] step_tgt;
  logic          step_up;
  logic signed [XW-1:0] freq_x;
  logic signed [XW-1:0] step_x;
  logic signed [XW-1:0] tgt_x;
  logic signed [XW-1:0] sum_x;
  logic [PW-1:0] next_word;

  // Next tuning word: step toward the active target, clamped to it. At the
  // turnaround point the target and direction are already the return leg's.
  always_comb begin
    at_tgt = (freq == tgt);
`ifdef DDS_SWEEP_BIDIR_EN
    turn = at_tgt && !back;
    step_tgt = turn ? origin : tgt;
`else
    turn = 1'b0;
    step_tgt = tgt;
`endif
    step_up = turn ? !dir_up : dir_up;
    freq_x = {{2{freq[PW-1]}}, freq};
    step_x = {2'b00, step_r};
    tgt_x = {{2{step_tgt[PW-1]}}, step_tgt};
    sum_x = step_up ? (freq_x + step_x) : (freq_x - step_x);
    if (step_r == '0)
      next_word = step_tgt;
    else if (step_up && (sum_x >= tgt_x))
      next_word = step_tgt;
    else if (!step_up && (sum_x <= tgt_x))
      next_word = step_tgt;
    else
      next_word = sum_x[PW-1:0];
  end

  // Sweep FSM with registered outputs; dwell timer is a down-counter that
  // advances the word when it reaches zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      freq   <= '0;
      phase  <= '0;
      dds_en <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      tgt    <= '0;
      step_r <= '0;
      reload <= '0;
      cnt    <= '0;
      dir_up <= 1'b0;
`ifdef DDS_SWEEP_BIDIR_EN
      origin <= '0;
      back   <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start && !abort) begin
            freq   <= f_start;
            phase  <= phase_in;
            tgt    <= f_stop;
            step_r <= f_step;
            reload <= (dwell == '0) ? '0 : dwell - CW'(1);
            cnt    <= (dwell == '0) ? '0 : dwell - CW'(1);
            dir_up <= ($signed(f_stop) >= $signed(f_start));
`ifdef DDS_SWEEP_BIDIR_EN
            origin <= f_start;
            back   <= 1'b0;
`endif
            busy   <= 1'b1;
            dds_en <= 1'b1;
            state  <= S_RUN;
          end
        end
        S_RUN: begin
          if (abort) begin
            busy   <= 1'b0;
            dds_en <= 1'b0;
            state  <= S_IDLE;
          end else if (cnt != '0) begin
            cnt <= cnt - CW'(1);
          end else if (!at_tgt) begin
            freq <= next_word;
            cnt  <= reload;
`ifdef DDS_SWEEP_BIDIR_EN
          end else if (!back && (origin != tgt)) begin
            freq   <= next_word;
            cnt    <= reload;
            tgt    <= origin;
            dir_up <= !dir_up;
            back   <= 1'b1;
`endif
          end else begin
            busy   <= 1'b0;
            dds_en <= 1'b0;
            done   <= 1'b1;
            state  <= S_FIN;
          end
        end
        S_FIN: begin
          state <= S_IDLE;
        end
        default: begin
          busy   <= 1'b0;
          dds_en <= 1'b0;
          state  <= S_IDLE;
        end
      endcase
    end
  end

endmodule
